llc_trace_feeder: RTL and testbench

- Upstream command stage for the LLC model. Accepts decoded trace commands (op code plus 32-bit address) from a file/stream source through a valid/ready handshake.
- Buffers them in a FIFO and presents exactly one command per issue slot on the LLC's op/addr inputs.
- Honours the LLC's hold back-pressure by stretching the current command.
- Filters illegal op codes and provides drain/count status so the bench knows when final statistics may be printed.

---
 rtl/llc_trace_feeder_if.sv | 28 ++
 rtl/llc_trace_feeder.sv | 157 +++++++++++++++
 tb/tb_llc_trace_feeder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/llc_trace_feeder_if.sv
// Trace feeder bus: the source-side valid/ready command handshake plus the
// LLC-side issue signals (op/addr/issue_valid) and the LLC's hold back-pressure.
//   in_valid/in_ready/in_op/in_addr : command source -> feeder
//   llc_op/llc_addr/issue_valid     : feeder -> LLC
//   hold                            : LLC -> feeder, stretch current command
// Modports: master = source/LLC side (bench), slave = feeder side.
interface llc_trace_feeder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic              hold;
  logic [31:0]       llc_op;
  logic [ADDR_W-1:0] llc_addr;
  logic              issue_valid;

  modport master (
    output in_valid, in_op, in_addr, hold,
    input  in_ready, llc_op, llc_addr, issue_valid
  );

  modport slave (
    input  in_valid, in_op, in_addr, hold,
    output in_ready, llc_op, llc_addr, issue_valid
  );
endinterface

// File: rtl/llc_trace_feeder.sv
// llc_trace_feeder: buffers decoded trace commands in a FIFO and presents one
// command per issue slot to the LLC, stretching it while the LLC asserts hold.
// Illegal op codes are handshaken but dropped and counted.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : source handshake in, LLC op/addr/issue_valid out, hold in
//   drained     : FIFO empty and no command on the LLC inputs
//   level       : FIFO occupancy
//   issue_cnt   : completed commands (issue_valid && !hold)
//   drop_cnt    : illegal commands discarded (saturating)
// Optional (macro LLC_FEED_ORDER_CHECK_EN): last_seq, seq_err -- per-entry
// sequence tags checking that completions come out in push order.
module llc_trace_feeder #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 32,
  parameter int IDLE_OP = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  llc_trace_feeder_if.slave      bus,
  output logic                   drained,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            issue_cnt,
  output logic [15:0]            drop_cnt
`ifdef LLC_FEED_ORDER_CHECK_EN
  ,
  output logic [31:0]            last_seq,
  output logic                   seq_err
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  logic [3:0]        op_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, empty, legal, accept, push, drop, pop, done;
  logic [31:0]       op_q;
  logic [ADDR_W-1:0] addr_q;
  state_t            state, state_nxt;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // Ready depends on registered occupancy only: a full FIFO refuses input
  // even when it pops in the same cycle.
  assign bus.in_ready = !full;

  always_comb begin
    legal = 1'b0;
    case (bus.in_op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal;
  assign drop   = accept && !legal;

  // Issue FSM: IDLE loads the head when available; ISSUE either stretches
  // (hold) or completes and reloads back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.hold) begin
          done = 1'b1;
          if (!empty) pop       = 1'b1;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset; occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= bus.in_op;
      addr_mem[wr_ptr] <= bus.in_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      op_q      <= 32'(IDLE_OP);
      addr_q    <= '0;
      issue_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);
      if (pop) begin
        op_q   <= {28'd0, op_mem[rd_ptr]};
        addr_q <= addr_mem[rd_ptr];
      end else if (done) begin
        op_q   <= 32'(IDLE_OP);
        addr_q <= '0;
      end
      if (done) issue_cnt <= issue_cnt + 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign bus.llc_op      = op_q;
  assign bus.llc_addr    = addr_q;
  assign bus.issue_valid = (state == S_ISSUE);
  assign drained         = empty && (state == S_IDLE);

`ifdef LLC_FEED_ORDER_CHECK_EN
  logic [31:0] seq_mem [DEPTH];
  logic [31:0] push_seq, cur_seq;

  always_ff @(posedge clk) begin
    if (push) seq_mem[wr_ptr] <= push_seq;
  end

  // last_seq sits at all-ones until the first completion so that tag 0
  // checks as the in-order successor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_seq <= '0;
      cur_seq  <= '0;
      last_seq <= '1;
      seq_err  <= 1'b0;
    end else begin
      if (push) push_seq <= push_seq + 1'b1;
      if (pop)  cur_seq  <= seq_mem[rd_ptr];
      if (done) begin
        last_seq <= cur_seq;
        if (cur_seq != last_seq + 32'd1) seq_err <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_llc_trace_feeder.sv
// Scoreboard bench for llc_trace_feeder: stimulus pushes the expected command
// for every accepted legal op; the monitor pops and compares on every
// completion (issue_valid && !hold). Directed checks cover reset, full,
// hold stretching, illegal-op filtering, mid-burst reset and concurrency.
module tb_llc_trace_feeder;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] op;
    logic [31:0] addr;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drained;
  logic [3:0]  level;
  logic [31:0] issue_cnt;
  logic [15:0] drop_cnt;
`ifdef LLC_FEED_ORDER_CHECK_EN
  logic [31:0] last_seq;
  logic        seq_err;
`endif

  int   errors = 0;
  int   checks = 0;
  cmd_t q[$];
  logic [31:0] ic0;

  llc_trace_feeder_if #(.ADDR_W(32)) bus ();

  llc_trace_feeder #(.DEPTH(DEPTH), .ADDR_W(32), .IDLE_OP(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .drained   (drained),
    .level     (level),
    .issue_cnt (issue_cnt),
    .drop_cnt  (drop_cnt)
`ifdef LLC_FEED_ORDER_CHECK_EN
    ,
    .last_seq  (last_seq),
    .seq_err   (seq_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return (op <= 4'd6) || (op == 4'd8) || (op == 4'd9);
  endfunction

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic push(input logic [3:0] op, input logic [31:0] addr);
    cmd_t c;
    int   k = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_addr  = addr;
    while (!bus.in_ready && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 200) chk("push_timeout", 64'(k), 0);
    @(posedge clk);
    if (is_legal(op)) begin
      c.op   = {28'd0, op};
      c.addr = addr;
      q.push_back(c);
    end
    #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drained();
    int k = 0;
    while (!drained && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("drain_in_time", 64'(drained), 1);
  endtask

  function automatic logic [3:0] rand_legal();
    int r = $urandom_range(0, 8);
    return (r <= 6) ? 4'(r) : 4'(r + 1);
  endfunction

  // Monitor: every completion must match the head of the scoreboard.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.issue_valid && !bus.hold) begin
        chk("sb_nonempty", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("issue_op", bus.llc_op, e.op);
          chk("issue_addr", bus.llc_addr, e.addr);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_addr  = '0;
    bus.hold     = 1'b0;
    cyc(2);
    // Reset state
    chk("rst_llc_op", bus.llc_op, 7);
    chk("rst_llc_addr", bus.llc_addr, 0);
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_drained", drained, 1);
    rst_n = 1'b1;
    cyc(1);

    // Single command latency
    push(4'd0, 32'h0000_1000);
    chk("t1_not_yet", bus.issue_valid, 0);
    cyc(1);
    chk("t1_valid", bus.issue_valid, 1);
    chk("t1_op", bus.llc_op, 0);
    chk("t1_addr", bus.llc_addr, 32'h1000);
    cyc(1);
    chk("t1_issue_cnt", issue_cnt, 1);
    chk("t1_drained", drained, 1);
    chk("t1_idle_op", bus.llc_op, 7);

    // Fill: one command held in the issue register, eight in the FIFO
    bus.hold = 1'b1;
    for (int i = 0; i < 9; i++) push(4'(i % 7), 32'h2000 + 32'(i * 4));
    chk("t2_level_full", level, 8);
    chk("t2_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'd3;
    bus.in_addr  = 32'hFFFF;
    cyc(3);
    chk("t2_no_accept_level", level, 8);
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    cyc(8);
    chk("t2_b2b_cnt", issue_cnt, 9);
    chk("t2_b2b_valid", bus.issue_valid, 1);
    cyc(1);
    chk("t2_final_cnt", issue_cnt, 10);
    chk("t2_drained", drained, 1);

    // Hold stretching for three cycles
    push(4'd1, 32'hABCD_0040);
    push(4'd2, 32'h0000_5000);
    bus.hold = 1'b1;
    ic0 = issue_cnt;
    chk("t3_op", bus.llc_op, 1);
    chk("t3_addr", bus.llc_addr, 32'hABCD_0040);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t3_addr_stable", bus.llc_addr, 32'hABCD_0040);
      chk("t3_cnt_stable", issue_cnt, ic0);
    end
    bus.hold = 1'b0;
    cyc(1);
    chk("t3_cnt_once", issue_cnt, ic0 + 1);
    chk("t3_next_op", bus.llc_op, 2);
    chk("t3_next_addr", bus.llc_addr, 32'h5000);
    wait_drained();

    // Illegal op filtering
    ic0 = issue_cnt;
    push(4'd7,  32'h3000);
    push(4'd2,  32'h3004);
    push(4'd10, 32'h3008);
    push(4'd9,  32'h300C);
    push(4'd15, 32'h3010);
    wait_drained();
    chk("t4_drop_cnt", drop_cnt, 3);
    chk("t4_issue_cnt", issue_cnt, ic0 + 2);

    // Reset mid-burst
    bus.hold = 1'b1;
    for (int i = 0; i < 6; i++) push(4'(i), 32'h4000 + 32'(i * 4));
    chk("t5_level", level, 5);
    chk("t5_active", bus.issue_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_op", bus.llc_op, 7);
    chk("t5_rst_addr", bus.llc_addr, 0);
    chk("t5_rst_valid", bus.issue_valid, 0);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_cnt", issue_cnt, 0);
    chk("t5_rst_drop", drop_cnt, 0);
    chk("t5_rst_drained", drained, 1);
    chk("t5_rst_ready", bus.in_ready, 1);
    q.delete();
    bus.hold = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    chk("t5_no_issue_cnt", issue_cnt, 0);
    chk("t5_no_issue_valid", bus.issue_valid, 0);

    // Concurrent push/pop around DEPTH-1 occupancy
    bus.hold = 1'b1;
    for (int i = 0; i < 8; i++) push(rand_legal(), $urandom);
    chk("t6_level", level, DEPTH - 1);
    bus.hold = 1'b0;
    for (int i = 8; i < 20; i++) push(rand_legal(), $urandom);
    wait_drained();
    chk("t6_issue_cnt", issue_cnt, 20);
    chk("t6_sb_empty", 64'(q.size()), 0);
`ifdef LLC_FEED_ORDER_CHECK_EN
    chk("t6_seq_err", seq_err, 0);
    chk("t6_last_seq", last_seq, 19);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
